// File: rtl/riscv_regs_pkg.sv
// riscv_regs_pkg: shared register-file types and constants.
package riscv_regs_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/riscv_scoreboard.sv
// riscv_scoreboard: per-register busy bits with flush > issue > write priority
// and a registered popcount of the busy vector.
module riscv_scoreboard
    import riscv_regs_pkg::*;
#(
    parameter int ADDR_LENGTH = 5,
    parameter int NUM_REGS    = 32
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write_en_i,
    input  logic [ADDR_LENGTH-1:0] write_addr_i,
    input  logic                   issue_en_i,
    input  logic [ADDR_LENGTH-1:0] issue_addr_i,
    input  logic                   flush_i,
    output logic [NUM_REGS-1:0]    busy_o,
    output logic [ADDR_LENGTH:0]   busy_count_o
);

    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [ADDR_LENGTH:0] cnt_q, cnt_d;
    logic                 wr_ok, iss_ok;

    assign wr_ok  = write_en_i && 32'(write_addr_i) != REG_ZERO && 32'(write_addr_i) < NUM_REGS;
    assign iss_ok = issue_en_i && 32'(issue_addr_i) != REG_ZERO && 32'(issue_addr_i) < NUM_REGS;

    // Issue is applied after write so a new producer wins on the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) busy_d[write_addr_i] = 1'b0;
        if (iss_ok) busy_d[issue_addr_i] = 1'b1;
        if (flush_i) busy_d = '0;
        cnt_d = '0;
        for (int i = 1; i < NUM_REGS; i++) cnt_d = cnt_d + {{ADDR_LENGTH{1'b0}}, busy_d[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = cnt_q;

endmodule

// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb: multi-port register file with x0 hard-wired, debug tap and RAW scoreboard.
// Define RISCV_REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module riscv_regfile_sb
    import riscv_regs_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_LENGTH = 5,
    parameter int NUM_REGS    = 32,
    parameter int NUM_READ    = 2,
    parameter int DEBUG_REG   = 3
)(
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_READ-1:0][ADDR_LENGTH-1:0] read_addr,
    output logic [NUM_READ-1:0][WORD_LENGTH-1:0] read_data,
    output logic [NUM_READ-1:0]                  read_busy,
    input  logic                                 write_en,
    input  logic [ADDR_LENGTH-1:0]               write_addr,
    input  logic [WORD_LENGTH-1:0]               data,
    input  logic                                 issue_en,
    input  logic [ADDR_LENGTH-1:0]               issue_addr,
    input  logic                                 flush,
    output logic [ADDR_LENGTH:0]                 busy_count,
    output logic [WORD_LENGTH-1:0]               debug_out
);

    logic [WORD_LENGTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]    busy;
    logic                   wr_ok;

    assign wr_ok = write_en && 32'(write_addr) != REG_ZERO && 32'(write_addr) < NUM_REGS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_ok) begin
            regs_q[write_addr] <= data;
        end
    end

    riscv_scoreboard #(
        .ADDR_LENGTH(ADDR_LENGTH),
        .NUM_REGS   (NUM_REGS)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .write_en_i  (write_en),
        .write_addr_i(write_addr),
        .issue_en_i  (issue_en),
        .issue_addr_i(issue_addr),
        .flush_i     (flush),
        .busy_o      (busy),
        .busy_count_o(busy_count)
    );

    for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
        logic in_range, hit;
        assign in_range = 32'(read_addr[g]) < NUM_REGS;
`ifdef RISCV_REGFILE_BYPASS_EN
        // A same-cycle issue is not forwarded: the busy bit appears next cycle.
        assign hit = wr_ok && read_addr[g] == write_addr;
`else
        assign hit = 1'b0;
`endif
        assign read_data[g] = hit ? data : in_range ? regs_q[read_addr[g]] : '0;
        assign read_busy[g] = !hit && in_range && busy[read_addr[g]];
    end

    assign debug_out = regs_q[DEBUG_REG];

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// tb_riscv_regfile_sb: directed table, corner sequences and randomized run against a register-file model.
module tb_riscv_regfile_sb;
    import riscv_regs_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0][4:0] read_addr = '0;
    logic [1:0][31:0] read_data;
    logic [1:0]      read_busy;
    logic            write_en = 1'b0;
    reg_addr_t       write_addr = '0;
    word_t           data = '0;
    logic            issue_en = 1'b0;
    reg_addr_t       issue_addr = '0;
    logic            flush = 1'b0;
    logic [5:0]      busy_count;
    word_t           debug_out;

    riscv_regfile_sb dut (
        .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(read_data),
        .read_busy(read_busy), .write_en(write_en), .write_addr(write_addr),
        .data(data), .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .busy_count(busy_count), .debug_out(debug_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit [31:0] m_regs [32];
    bit [31:0] m_busy;

    typedef struct {
        logic we; logic [4:0] wa; logic [31:0] wd;
        logic ie; logic [4:0] ia; logic fl;
        logic [4:0] r0; logic [4:0] r1;
        logic [31:0] d0; logic b0; logic [31:0] d1; logic b1;
        logic [5:0] cnt; logic [31:0] dbg;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_busy = 0;
    endtask

    task automatic model_edge();
        if (write_en && write_addr != 0) begin
            m_regs[write_addr] = data;
            m_busy[write_addr] = 1'b0;
        end
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        if (flush) m_busy = 0;
    endtask

    task automatic check_model(input string tag);
        for (int p = 0; p < 2; p++) begin
            bit [31:0] ed;
            bit eb;
            ed = m_regs[read_addr[p]];
            eb = m_busy[read_addr[p]];
`ifdef RISCV_REGFILE_BYPASS_EN
            if (write_en && write_addr != 0 && read_addr[p] == write_addr) begin
                ed = data;
                eb = 1'b0;
            end
`endif
            chk($sformatf("%s data%0d", tag, p), read_data[p], ed);
            chk($sformatf("%s busy%0d", tag, p), 32'(read_busy[p]), 32'(eb));
        end
        chk({tag, " count"}, 32'(busy_count), $countones(m_busy));
        chk({tag, " debug"}, debug_out, m_regs[3]);
    endtask

    task automatic idle();
        write_en = 0; issue_en = 0; flush = 0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_edge();
        #1;
        idle();
    endtask

    initial begin
        model_reset();
        read_addr[0] = 5'd3;
        read_addr[1] = 5'd7;
        #2;
        chk("reset data0", read_data[0], 32'h0);
        chk("reset busy", 32'(read_busy), 32'h0);
        chk("reset count", 32'(busy_count), 32'h0);
        chk("reset debug", debug_out, 32'h0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        tbl[0] = '{1, 5'd3,  32'h55,       0, 5'd0,  0, 5'd3,  5'd3,  32'h55,       0, 32'h55, 0, 6'd0, 32'h55};
        tbl[1] = '{0, 5'd0,  32'h0,        1, 5'd5,  0, 5'd5,  5'd3,  32'h0,        1, 32'h55, 0, 6'd1, 32'h55};
        tbl[2] = '{1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  0, 5'd0,  5'd5,  32'h0,        0, 32'h0,  1, 6'd1, 32'h55};
        tbl[3] = '{1, 5'd9,  32'hA5,       1, 5'd9,  0, 5'd9,  5'd5,  32'hA5,       1, 32'h0,  1, 6'd2, 32'h55};
        tbl[4] = '{1, 5'd5,  32'h1234,     0, 5'd0,  0, 5'd5,  5'd9,  32'h1234,     0, 32'hA5, 1, 6'd1, 32'h55};
        tbl[5] = '{1, 5'd11, 32'h77,       1, 5'd10, 1, 5'd10, 5'd11, 32'h0,        0, 32'h77, 0, 6'd0, 32'h55};
        tbl[6] = '{0, 5'd0,  32'h0,        1, 5'd31, 0, 5'd31, 5'd1,  32'h0,        1, 32'h0,  0, 6'd1, 32'h55};
        tbl[7] = '{1, 5'd31, 32'hCAFEF00D, 1, 5'd2,  0, 5'd31, 5'd2,  32'hCAFEF00D, 0, 32'h0,  1, 6'd1, 32'h55};
        tbl[8] = '{1, 5'd3,  32'h66,       0, 5'd0,  0, 5'd3,  5'd0,  32'h66,       0, 32'h0,  0, 6'd1, 32'h66};

        for (int v = 0; v < 9; v++) begin
            write_en = tbl[v].we; write_addr = tbl[v].wa; data = tbl[v].wd;
            issue_en = tbl[v].ie; issue_addr = tbl[v].ia; flush = tbl[v].fl;
            edge_step();
            read_addr[0] = tbl[v].r0;
            read_addr[1] = tbl[v].r1;
            @(negedge clk);
            chk($sformatf("vec%0d data0", v), read_data[0], tbl[v].d0);
            chk($sformatf("vec%0d busy0", v), 32'(read_busy[0]), 32'(tbl[v].b0));
            chk($sformatf("vec%0d data1", v), read_data[1], tbl[v].d1);
            chk($sformatf("vec%0d busy1", v), 32'(read_busy[1]), 32'(tbl[v].b1));
            chk($sformatf("vec%0d count", v), 32'(busy_count), 32'(tbl[v].cnt));
            chk($sformatf("vec%0d debug", v), debug_out, tbl[v].dbg);
            @(posedge clk);
            #1;
        end

        // Issue x5, write it three cycles later.
        flush = 1;
        edge_step();
        issue_en = 1; issue_addr = 5'd5;
        edge_step();
        read_addr[0] = 5'd5;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("raw cyc%0d busy", c), 32'(read_busy[0]), 32'h1);
            chk($sformatf("raw cyc%0d count", c), 32'(busy_count), 32'h1);
            #1;
            if (c == 3) begin
                write_en = 1; write_addr = 5'd5; data = 32'h1234;
            end
            edge_step();
        end
        @(negedge clk);
        chk("raw cyc4 data", read_data[0], 32'h1234);
        chk("raw cyc4 busy", 32'(read_busy[0]), 32'h0);
        chk("raw cyc4 count", 32'(busy_count), 32'h0);

        // Same-cycle read of a register being written (and re-issued).
        @(posedge clk);
        #1;
        write_en = 1; write_addr = 5'd4; data = 32'h10;
        edge_step();
        write_en = 1; write_addr = 5'd4; data = 32'h20;
        issue_en = 1; issue_addr = 5'd4;
        read_addr[0] = 5'd4;
        @(negedge clk);
`ifdef RISCV_REGFILE_BYPASS_EN
        chk("bypass data", read_data[0], 32'h20);
`else
        chk("bypass data", read_data[0], 32'h10);
`endif
        chk("bypass busy", 32'(read_busy[0]), 32'h0);
        edge_step();
        @(negedge clk);
        chk("bypass next data", read_data[0], 32'h20);
        chk("bypass next busy", 32'(read_busy[0]), 32'h1);

        // Asynchronous reset between edges.
        @(posedge clk);
        #1;
        issue_en = 1; issue_addr = 5'd5;
        write_en = 1; write_addr = 5'd7; data = 32'hDEADBEEF;
        edge_step();
        read_addr[0] = 5'd7;
        @(negedge clk);
        chk("pre-reset data", read_data[0], 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1;
        chk("async reset data", read_data[0], 32'h0);
        chk("async reset count", 32'(busy_count), 32'h0);
        chk("async reset debug", debug_out, 32'h0);
        model_reset();
        write_en = 1; write_addr = 5'd6; data = 32'h42;
        #1 rst = 1'b0;
        edge_step();
        read_addr[0] = 5'd6;
        @(negedge clk);
        chk("post-reset write", read_data[0], 32'h42);

        // Randomized run against the model.
        @(posedge clk);
        #1;
        for (int n = 0; n < 600; n++) begin
            write_en   = ($urandom_range(0, 99) < 50);
            write_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            data       = $urandom;
            issue_en   = ($urandom_range(0, 99) < 45);
            issue_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 99) < 4);
            read_addr[0] = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 7));
            read_addr[1] = 5'($urandom);
            @(negedge clk);
            check_model($sformatf("rnd%0d", n));
            edge_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
